// File: rtl/playbus_master_if.sv
// playbus_master_if: command handshake and PlayBus strobe bundle
// Ports (master view):
//   cmd_valid, cmd_op[1:0]               in   command offer
//   cmd_ready, busy, done                out  queue and transfer status
//   SWBEN, RAMO, ROMO, RAMW, LEDLTCH     out  source enables / sink selects
//   n_clk                                out  active-low latch clock
interface playbus_master_if;
  logic       cmd_valid;
  logic [1:0] cmd_op;
  logic       cmd_ready;
  logic       busy;
  logic       done;
  logic       SWBEN;
  logic       RAMO;
  logic       ROMO;
  logic       RAMW;
  logic       LEDLTCH;
  logic       n_clk;
  modport master (
    input  cmd_valid, cmd_op,
    output cmd_ready, busy, done, SWBEN, RAMO, ROMO, RAMW, LEDLTCH, n_clk
  );
  modport slave (
    output cmd_valid, cmd_op,
    input  cmd_ready, busy, done, SWBEN, RAMO, ROMO, RAMW, LEDLTCH, n_clk
  );
endinterface

// File: rtl/playbus_master.sv
// playbus_master: queued PlayBus transfer initiator driving source/sink strobes and n_clk
// Ports:
//   clk    in  system clock, rising edge
//   reset  in  asynchronous reset, active-high
//   bus    playbus_master_if.master (command handshake, status, bus strobes)
// Optional feature: define PLAYBUS_TURNAROUND_EN to insert a one-cycle idle TURN
// state between back-to-back transfers whose bus source differs.
module playbus_master #(
  parameter int DEPTH      = 4,
  parameter int SETUP_CYC  = 1,
  parameter int STROBE_CYC = 2,
  parameter int HOLD_CYC   = 1
) (
  input logic clk,
  input logic reset,
  playbus_master_if.master bus
);
  localparam int AW   = $clog2(DEPTH);
  localparam int MAXC = (SETUP_CYC > STROBE_CYC)
                      ? ((SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC)
                      : ((STROBE_CYC > HOLD_CYC) ? STROBE_CYC : HOLD_CYC);
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] S_LD = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] T_LD = CW'(STROBE_CYC - 1);
  localparam logic [CW-1:0] H_LD = CW'(HOLD_CYC - 1);
  typedef enum logic [2:0] {
    IDLE, SETUP, STROBE, HOLD
`ifdef PLAYBUS_TURNAROUND_EN
    , TURN
`endif
  } state_t;
  state_t        state, nxt;
  logic [CW-1:0] cnt, ncnt;
  logic [1:0]    op, nop, head;
  logic [AW:0]   wr_ptr, rd_ptr;
  logic [1:0]    mem [DEPTH];
  logic          empty, full, push, pop, start, act;
`ifdef PLAYBUS_TURNAROUND_EN
  // SW->LED and SW->RAM share the switch buffer as source
  function automatic logic [1:0] src(input logic [1:0] o);
    return o[1] ? o : 2'b00;
  endfunction
`endif
  assign empty         = wr_ptr == rd_ptr;
  assign full          = (wr_ptr ^ rd_ptr) == {1'b1, {AW{1'b0}}};
  assign push          = bus.cmd_valid && !full;
  assign head          = mem[rd_ptr[AW-1:0]];
  assign bus.cmd_ready = !full;
  assign bus.busy      = (state != IDLE) || !empty;
  always_ff @(posedge clk)
    if (push) mem[wr_ptr[AW-1:0]] <= bus.cmd_op;
  // cnt counts down the remaining cycles of the current phase, reloaded on entry
  always_comb begin
    nxt   = state;
    ncnt  = cnt - 1'b1;
    nop   = op;
    pop   = 1'b0;
    start = 1'b0;
    case (state)
      IDLE:   start = !empty;
      SETUP:  if (cnt == '0) begin
                nxt  = STROBE;
                ncnt = T_LD;
              end
      STROBE: if (cnt == '0) begin
                nxt  = HOLD;
                ncnt = H_LD;
              end
      HOLD:   if (cnt == '0) begin
                nxt   = IDLE;
                start = !empty;
`ifdef PLAYBUS_TURNAROUND_EN
                if (!empty && src(head) != src(op)) begin
                  start = 1'b0;
                  nxt   = TURN;
                end
`endif
              end
`ifdef PLAYBUS_TURNAROUND_EN
      TURN:   start = 1'b1;
`endif
      default: nxt = IDLE;
    endcase
    if (start) begin
      pop  = 1'b1;
      nop  = head;
      nxt  = SETUP;
      ncnt = S_LD;
    end
  end
  // Strobes are registered from the next state so they change exactly with it
  assign act = (nxt == SETUP) || (nxt == STROBE) || (nxt == HOLD);
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      op          <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      bus.SWBEN   <= 1'b0;
      bus.RAMO    <= 1'b0;
      bus.ROMO    <= 1'b0;
      bus.RAMW    <= 1'b0;
      bus.LEDLTCH <= 1'b0;
      bus.n_clk   <= 1'b1;
      bus.done    <= 1'b0;
    end else begin
      state       <= nxt;
      cnt         <= ncnt;
      op          <= nop;
      wr_ptr      <= push ? wr_ptr + 1'b1 : wr_ptr;
      rd_ptr      <= pop ? rd_ptr + 1'b1 : rd_ptr;
      bus.SWBEN   <= act && !nop[1];
      bus.RAMO    <= act && nop == 2'b10;
      bus.ROMO    <= act && nop == 2'b11;
      bus.RAMW    <= act && nop == 2'b01;
      bus.LEDLTCH <= act && nop != 2'b01;
      bus.n_clk   <= nxt != STROBE;
      bus.done    <= nxt == HOLD && ncnt == '0;
    end
endmodule

// File: tb/tb_playbus_master.sv
// tb_playbus_master: scoreboard bench for playbus_master with directed and random traffic
module tb_playbus_master;
  localparam int S = 1, T = 2, H = 1, D = 4;
`ifdef PLAYBUS_TURNAROUND_EN
  localparam int GAP = 1;
`else
  localparam int GAP = 0;
`endif
  logic clk = 1'b0;
  logic reset = 1'b1;
  playbus_master_if bus();
  playbus_master #(.DEPTH(D), .SETUP_CYC(S), .STROBE_CYC(T), .HOLD_CYC(H)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  always #5 clk = ~clk;
  int n_cmp = 0, n_bad = 0, cyc = 0, done_cnt = 0, n_acc = 0;
  int len = 0, gap = 0, last_gap = -1;
  logic [1:0]  exp_q[$];
  logic [4:0]  vec, first_vec;
  logic [31:0] pat;
  bit          varied;
  assign vec = {bus.SWBEN, bus.RAMO, bus.ROMO, bus.RAMW, bus.LEDLTCH};
  always @(posedge clk) cyc <= cyc + 1;
  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction
  // {SWBEN,RAMO,ROMO,RAMW,LEDLTCH} required for each op
  function automatic logic [4:0] strobes_for(input logic [1:0] op);
    case (op)
      2'b00:   return 5'b10001;
      2'b01:   return 5'b10010;
      2'b10:   return 5'b01001;
      default: return 5'b00101;
    endcase
  endfunction
  // n_clk over one transfer, oldest cycle in the most significant position
  function automatic logic [31:0] exp_pat();
    logic [31:0] p = '0;
    for (int i = 0; i < S; i++) p = {p[30:0], 1'b1};
    for (int i = 0; i < T; i++) p = {p[30:0], 1'b0};
    for (int i = 0; i < H; i++) p = {p[30:0], 1'b1};
    return p;
  endfunction
  task automatic offer(input logic [1:0] op, output bit acc);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    acc           = bus.cmd_ready;
    if (acc) begin
      exp_q.push_back(op);
      n_acc++;
    end
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask
  task automatic drain();
    for (int i = 0; i < 400 && (bus.busy || exp_q.size() != 0); i++) @(negedge clk);
    chk("drain_busy", bus.busy, 0);
    chk("drain_queue", exp_q.size(), 0);
  endtask
  initial begin : monitor
    logic [1:0] e;
    forever begin
      @(negedge clk);
      if (reset) begin
        len = 0; gap = 0; pat = '0; varied = 0;
      end else begin
        chk("src_onehot", $countones(vec[4:2]) <= 1, 1);
        chk("sink_excl", vec[1] & vec[0], 0);
        chk("nclk_idle", vec == 0 && !bus.n_clk, 0);
        if (vec != 0) begin
          if (len == 0) begin
            last_gap  = gap;
            first_vec = vec;
            varied    = 0;
          end else if (vec != first_vec) varied = 1;
          pat = {pat[30:0], bus.n_clk};
          len++;
        end else if (len == 0) gap++;
        if (bus.done) begin
          if (exp_q.size() == 0) chk("done_unexpected", 1, 0);
          else begin
            e = exp_q.pop_front();
            chk("xfer_strobes", first_vec, strobes_for(e));
            chk("xfer_stable", varied, 0);
            chk("xfer_len", len, S + T + H);
            chk("xfer_nclk", pat, exp_pat());
          end
          done_cnt++;
          len = 0; pat = '0; gap = 0;
        end
      end
    end
  end
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    bit acc;
    int c0, d0, a0, k;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'b00;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_strobes", vec, 0);
    chk("rst_nclk", bus.n_clk, 1);
    chk("rst_busy", bus.busy, 0);
    chk("rst_ready", bus.cmd_ready, 1);
    chk("rst_done", bus.done, 0);
    // single SW->LED transfer: latency and done/busy relationship
    c0 = cyc;
    offer(2'b00, acc);
    chk("single_accept", acc, 1);
    for (int i = 0; i < 20 && bus.n_clk; i++) @(negedge clk);
    chk("latency", cyc - c0, 2 + S);
    for (int i = 0; i < 20 && !bus.done; i++) @(negedge clk);
    chk("single_done", bus.done, 1);
    chk("busy_at_done", bus.busy, 1);
    @(negedge clk);
    chk("busy_after_done", bus.busy, 0);
    chk("done_one_cycle", bus.done, 0);
    drain();
    // five gapless commands fill the queue
    d0 = done_cnt;
    for (int i = 0; i < 5; i++) begin
      acc = 0;
      k   = 0;
      while (!acc && k < 20) begin
        offer(2'($urandom_range(0, 3)), acc);
        k++;
      end
    end
    chk("full_ready_low", bus.cmd_ready, 0);
    offer(2'($urandom_range(0, 3)), acc);
    chk("full_reject", acc, 0);
    for (int i = 0; i < 10 && !bus.cmd_ready; i++) @(negedge clk);
    chk("ready_rises", bus.cmd_ready, 1);
    drain();
    chk("five_done", done_cnt - d0, 5);
    // SW->RAM then RAM->LED back-to-back
    offer(2'b01, acc);
    offer(2'b10, acc);
    d0 = done_cnt;
    for (int i = 0; i < 40 && done_cnt < d0 + 2; i++) @(negedge clk);
    chk("b2b_done", done_cnt - d0, 2);
    chk("turn_gap", last_gap, GAP);
    drain();
    // reset in the middle of a ROM->LED strobe with more work queued
    offer(2'b11, acc);
    offer(2'b10, acc);
    offer(2'b01, acc);
    for (int i = 0; i < 20 && bus.n_clk; i++) @(negedge clk);
    chk("strobe_reached", bus.n_clk, 0);
    chk("strobe_romo", bus.ROMO, 1);
    #2 reset = 1'b1;
    #1;
    chk("async_romo", bus.ROMO, 0);
    chk("async_ledltch", bus.LEDLTCH, 0);
    chk("async_nclk", bus.n_clk, 1);
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_busy", bus.busy, 0);
    chk("post_rst_ready", bus.cmd_ready, 1);
    repeat (4) @(negedge clk);
    chk("post_rst_idle", vec, 0);
    chk("post_rst_empty", bus.busy, 0);
    // random traffic
    d0 = done_cnt;
    a0 = n_acc;
    repeat (1000) begin
      if ($urandom_range(0, 1) == 1) offer(2'($urandom_range(0, 3)), acc);
      else @(negedge clk);
    end
    drain();
    chk("done_eq_accepted", done_cnt - d0, n_acc - a0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
